ds_cmd_sequencer: RTL and testbench
===================================

# ds_cmd_sequencer

Command sequencer between application logic and the DS1302 byte-level read/write engine. It accepts generic register commands through a valid/ready port and buffers them in a parametrised FIFO. Each command is translated into the DS1302 command byte and write data, and the engine is driven through the func_start/func_done handshake. Every completed command returns one response pulse carrying read data and status, replacing hard-coded one-hot command decoding with arbitrary clock/RAM register access.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 65536, max cycles in ISSUE before abort (timeout build only)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_ram  in  1  1 = RAM space, 0 = clock/calendar space
- cmd_reg  in  5  register index 0..31
- cmd_wdata  in  8  write data (ignored for reads)
- func_start  out  2  2'b10 write, 2'b01 read, 2'b00 idle
- func_done  in  1  engine completion pulse
- func_rdata  in  8  engine read byte, valid with func_done
- register_addr  out  8  DS1302 command byte
- write_data  out  8  byte to write
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  completed command was a write
- rsp_rdata  out  8  read data; 8'h00 for writes and timeouts
- rsp_timeout  out  1  completion was a timeout abort
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored

## Operation
- Push on clock edge with cmd_valid && cmd_ready; 15-bit entry {write, ram, reg, wdata}. cmd_ready = (fifo_level != FIFO_DEPTH).
- Push and pop in same cycle allowed; level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Command byte: register_addr = {1'b1, cmd_ram, cmd_reg, ~cmd_write}. Example: write clock reg 1 → 8'h82; read RAM reg 3 → 8'hC7.
- FSM states IDLE, ISSUE, RESP:
  - IDLE: FIFO non-empty → pop; load register_addr and write_data (write_data keeps its previous value on reads); func_start ← 10/01; → ISSUE.
  - ISSUE: hold func_start. On func_done: func_start ← 00; rsp_valid ← 1; rsp_write ← entry write bit; rsp_rdata ← write ? 8'h00 : func_rdata; rsp_timeout ← 0; → RESP.
  - RESP: rsp_valid ← 0; → IDLE.
- func_done outside ISSUE is ignored.
- Reset, including mid-command: FIFO emptied; state IDLE; all outputs 0 (cmd_ready 1 after reset); aborted command produces no response.

## Timing
- Push at edge E0 into empty idle block → func_start and register_addr valid after E1.
- func_done sampled high at edge En → func_start 00 and rsp_valid high after En; rsp_valid low after En+1; next pop no earlier than En+2.
- Back-to-back throughput: issue-to-done time + 2 cycles per command.
- fifo_level and cmd_ready update on the edge following push/pop.

## Configuration
- DS_CMD_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES) cleared on entry to ISSUE and incremented each ISSUE cycle. If it reaches TIMEOUT_CYCLES-1 with func_done low: func_start ← 00, rsp_valid ← 1, rsp_timeout ← 1, rsp_rdata ← 00, → RESP. func_done in the same cycle wins, giving a normal completion.
- DS_CMD_TIMEOUT_EN undefined: no counter; ISSUE waits indefinitely; rsp_timeout tied 0.

## Test plan
- Write clock reg 1, data 8'h21; engine done 20 cycles later → register_addr 8'h82, write_data 8'h21, func_start 2'b10 until done; one rsp_valid pulse with rsp_write=1, rsp_rdata 00.
- Read clock reg 0; func_rdata 8'h45 with func_done → register_addr 8'h81, func_start 01, rsp_rdata 8'h45, rsp_write 0.
- Read RAM reg 3 → register_addr 8'hC7.
- FIFO_DEPTH=4, engine stalled, 5 pushes attempted → 4 accepted, cmd_ready low, fifo_level 4. Release engine → commands execute in order with 2 idle cycles between completions.
- Timeout build, TIMEOUT_CYCLES=16, func_done never asserted → abort after 16 ISSUE cycles with rsp_timeout=1, rsp_rdata 00; next queued command starts.
- rst_n low mid-ISSUE with 2 entries queued → func_start 00, fifo_level 0, no rsp_valid; after release, stray func_done is ignored.

Source files
------------

// File: rtl/ds_cmd_sequencer.sv
// Register-command sequencer for the DS1302 byte engine: FIFO-buffered commands in, one response each.
// Optional build macro DS_CMD_TIMEOUT_EN adds an ISSUE-state watchdog that aborts stalled commands.
module ds_cmd_sequencer #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic                          cmd_ram,
   input  logic [4:0]                    cmd_reg,
   input  logic [7:0]                    cmd_wdata,
   output logic [1:0]                    func_start,
   input  logic                          func_done,
   input  logic [7:0]                    func_rdata,
   output logic [7:0]                    register_addr,
   output logic [7:0]                    write_data,
   output logic                          rsp_valid,
   output logic                          rsp_write,
   output logic [7:0]                    rsp_rdata,
   output logic                          rsp_timeout,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 2))
   begin : g_param_check
      $error("ds_cmd_sequencer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e         state_q, state_d;
   logic [14:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]  level_q, level_d;
   logic           push, pop;
   logic [14:0]    head;

   logic [1:0]     func_start_q, func_start_d;
   logic [7:0]     addr_q, addr_d;
   logic [7:0]     wdata_q, wdata_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_write_q, rsp_write_d;
   logic [7:0]     rsp_rdata_q, rsp_rdata_d;
   logic           rsp_timeout_q, rsp_timeout_d;

`ifdef DS_CMD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0]  tmo_q, tmo_d;
`endif

   assign cmd_ready = (level_q != LW'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Entry layout {write, ram, reg[4:0], wdata[7:0]}.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_ram, cmd_reg, cmd_wdata};
   end

   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      func_start_d  = func_start_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rsp_valid_d   = 1'b0;
      rsp_write_d   = rsp_write_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;
`ifdef DS_CMD_TIMEOUT_EN
      tmo_d         = tmo_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (level_q != '0) begin
               pop          = 1'b1;
               addr_d       = {1'b1, head[13], head[12:8], ~head[14]};
               if (head[14]) wdata_d = head[7:0];
               func_start_d = head[14] ? 2'b10 : 2'b01;
`ifdef DS_CMD_TIMEOUT_EN
               tmo_d        = '0;
`endif
               state_d      = StIssue;
            end
         end
         StIssue: begin
            // func_start_q[1] still carries the write bit of the command in flight.
            if (func_done) begin
               func_start_d  = 2'b00;
               rsp_valid_d   = 1'b1;
               rsp_write_d   = func_start_q[1];
               rsp_rdata_d   = func_start_q[1] ? 8'h00 : func_rdata;
               rsp_timeout_d = 1'b0;
               state_d       = StResp;
            end
`ifdef DS_CMD_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               func_start_d  = 2'b00;
               rsp_valid_d   = 1'b1;
               rsp_write_d   = func_start_q[1];
               rsp_rdata_d   = 8'h00;
               rsp_timeout_d = 1'b1;
               state_d       = StResp;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         func_start_q  <= 2'b00;
         addr_q        <= 8'h00;
         wdata_q       <= 8'h00;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= 8'h00;
         rsp_timeout_q <= 1'b0;
`ifdef DS_CMD_TIMEOUT_EN
         tmo_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q       <= level_d;
         func_start_q  <= func_start_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
`ifdef DS_CMD_TIMEOUT_EN
         tmo_q         <= tmo_d;
`endif
      end
   end

   assign func_start    = func_start_q;
   assign register_addr = addr_q;
   assign write_data    = wdata_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign busy          = (state_q != StIdle) || (level_q != '0);
   assign fifo_level    = level_q;

endmodule

// File: tb/tb_ds_cmd_sequencer.sv
// Self-checking bench for ds_cmd_sequencer: directed steps plus randomized commands
// checked against a queue-based model of the command stream.
module tb_ds_cmd_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_write, cmd_ram;
   logic [4:0] cmd_reg;
   logic [7:0] cmd_wdata;
   logic [1:0] func_start;
   logic       func_done;
   logic [7:0] func_rdata, register_addr, write_data, rsp_rdata;
   logic       rsp_valid, rsp_write, rsp_timeout, busy;
   logic [2:0] fifo_level;

   ds_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_ram(cmd_ram), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .func_start(func_start), .func_done(func_done), .func_rdata(func_rdata),
      .register_addr(register_addr), .write_data(write_data),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout), .busy(busy), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       w;
      bit       ram;
      bit [4:0] rg;
      bit [7:0] wd;
   } cmd_t;

   cmd_t       q[$];
   logic [7:0] last_wd;
   int         total = 0;
   int         bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input bit w, input bit ram, input bit [4:0] rg, input bit [7:0] wd,
                           output bit acc);
      cmd_t c;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_ram   = ram;
      cmd_reg   = rg;
      cmd_wdata = wd;
      acc = cmd_ready;
      tick();
      if (acc) begin
         c.w = w; c.ram = ram; c.rg = rg; c.wd = wd;
         q.push_back(c);
      end
   endtask

   task automatic push_rand(output bit acc);
      push_one(1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), acc);
   endtask

   // Acts as the engine for the next command; checks issue, response pulse and its end.
   task automatic serve(input int hold, input logic [7:0] rd, output int waited);
      cmd_t       c;
      logic [7:0] exp_addr;
      waited = 0;
      while (func_start == 2'b00 && waited < 100) begin
         tick();
         waited++;
      end
      chk("serve_start_seen", 32'(func_start != 2'b00), 1);
      if (func_start == 2'b00) return;
      chk("model_nonempty", 32'(q.size() != 0), 1);
      if (q.size() == 0) return;
      c = q.pop_front();
      exp_addr = 8'(128 + (c.ram ? 64 : 0) + 2 * int'(c.rg) + (c.w ? 0 : 1));
      if (c.w) last_wd = c.wd;
      chk("register_addr", register_addr, exp_addr);
      chk("write_data", write_data, last_wd);
      chk("func_start", func_start, c.w ? 2 : 1);
      repeat (hold) tick();
      chk("func_start_held", func_start, c.w ? 2 : 1);
      chk("rsp_idle_in_issue", rsp_valid, 0);
      func_rdata = rd;
      func_done  = 1'b1;
      tick();
      func_done  = 1'b0;
      func_rdata = 8'($urandom);
      chk("func_start_clr", func_start, 0);
      chk("rsp_valid_hi", rsp_valid, 1);
      chk("rsp_write", rsp_write, c.w);
      chk("rsp_rdata", rsp_rdata, c.w ? 0 : rd);
      chk("rsp_timeout", rsp_timeout, 0);
      tick();
      chk("rsp_valid_lo", rsp_valid, 0);
   endtask

   initial begin
      bit acc;
      int waited, naccept, k, cnt;

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_ram = 1'b0; cmd_reg = '0; cmd_wdata = '0;
      func_done = 1'b0; func_rdata = '0;
      last_wd = 8'h00;
      repeat (3) tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_func_start", func_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_register_addr", register_addr, 0);
      rst_n = 1'b1;
      tick();

      // Write clock reg 1, first-issue latency, long engine delay.
      push_one(1'b1, 1'b0, 5'd1, 8'h21, acc);
      cmd_valid = 1'b0;
      chk("lvl_after_push", fifo_level, 1);
      chk("func_start_pre", func_start, 0);
      tick();
      chk("issue_latency", func_start, 2);
      serve(20, 8'h5A, waited);
      chk("issue_wait", waited, 0);

      // Read clock reg 0, then read RAM reg 3.
      push_one(1'b0, 1'b0, 5'd0, 8'h00, acc);
      cmd_valid = 1'b0;
      serve(3, 8'h45, waited);
      push_one(1'b0, 1'b1, 5'd3, 8'hEE, acc);
      cmd_valid = 1'b0;
      serve(1, 8'($urandom), waited);

      // Engine stalled on one command; five more offered back-to-back.
      push_rand(acc);
      cmd_valid = 1'b0;
      tick();
      naccept = 0;
      for (int i = 0; i < 5; i++) begin
         push_rand(acc);
         if (acc) naccept++;
      end
      cmd_valid = 1'b0;
      chk("fifo_accepts", naccept, DEPTH);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_level", fifo_level, DEPTH);
      chk("full_busy", busy, 1);
      serve(2, 8'($urandom), waited);
      for (int i = 0; i < int'(DEPTH); i++) begin
         serve(int'($urandom_range(0, 4)), 8'($urandom), waited);
         chk("b2b_gap", waited, 1);
      end
      chk("drained_level", fifo_level, 0);
      chk("drained_busy", busy, 0);

      // Randomized batches.
      for (int n = 0; n < 25; n++) begin
         k = int'($urandom_range(1, 3));
         for (int i = 0; i < k; i++) push_rand(acc);
         cmd_valid = 1'b0;
         for (int i = 0; i < k; i++)
            serve(int'($urandom_range(0, 5)), 8'($urandom), waited);
      end
      chk("rand_drained", fifo_level, 0);

`ifdef DS_CMD_TIMEOUT_EN
      // Stalled read aborts after TMO issue cycles; the queued write then runs.
      push_one(1'b0, 1'b0, 5'd7, 8'h00, acc);
      push_one(1'b1, 1'b1, 5'd9, 8'h3C, acc);
      cmd_valid = 1'b0;
      cnt = 0;
      while (func_start == 2'b00 && cnt < 10) begin tick(); cnt++; end
      chk("tmo_issue", func_start, 1);
      void'(q.pop_front());
      cnt = 0;
      while (!rsp_valid && cnt < 100) begin tick(); cnt++; end
      chk("tmo_cycles", cnt, TMO);
      chk("tmo_flag", rsp_timeout, 1);
      chk("tmo_rdata", rsp_rdata, 0);
      chk("tmo_write", rsp_write, 0);
      chk("tmo_start_clr", func_start, 0);
      tick();
      chk("tmo_rsp_lo", rsp_valid, 0);
      serve(2, 8'($urandom), waited);
      chk("tmo_next_gap", waited, 1);
`endif

      // Reset mid-ISSUE with two entries queued.
      for (int i = 0; i < 3; i++) push_rand(acc);
      cmd_valid = 1'b0;
      tick();
      chk("pre_rst_level", fifo_level, 2);
      chk("pre_rst_issue", 32'(func_start != 2'b00), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_start", func_start, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      q.delete();
      last_wd = 8'h00;
      tick();
      rst_n = 1'b1;
      func_done = 1'b1;
      func_rdata = 8'hA5;
      tick();
      func_done = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid || func_start != 2'b00 || busy) cnt++;
         tick();
      end
      chk("stray_done_ignored", cnt, 0);
      chk("post_rst_level", fifo_level, 0);
      push_one(1'b0, 1'b1, 5'd31, 8'h00, acc);
      cmd_valid = 1'b0;
      serve(2, 8'h99, waited);
      chk("post_rst_wd", write_data, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
